// File: rtl/ex_muldiv_sequencer.sv
// Iterative multiply/divide unit for the EX stage: 32-step shift-add multiply and
// restoring divide, with sign pre/post correction and HI/LO result registers.
module ex_muldiv_sequencer #(
    parameter int NB_INST  = 32,
    parameter int NB_COUNT = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [1:0]         i_op,
    input  logic [NB_INST-1:0] i_operand_a,
    input  logic [NB_INST-1:0] i_operand_b,
    input  logic               i_flush,
    output logic               o_stall,
    output logic               o_done,
    output logic [NB_INST-1:0] o_hi,
    output logic [NB_INST-1:0] o_lo,
    output logic               o_div_by_zero
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        RUN  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [NB_COUNT-1:0] LAST_CNT = NB_COUNT'(NB_INST - 1);

    function automatic logic signed [NB_INST-1:0] neg_w(input logic signed [NB_INST-1:0] x);
        return -x;
    endfunction

    function automatic logic signed [2*NB_INST-1:0] neg_dw(input logic signed [2*NB_INST-1:0] x);
        return -x;
    endfunction

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [NB_INST-1:0]    a_q, a_d;
    logic [NB_INST-1:0]    b_q, b_d;
    logic [NB_INST-1:0]    mag_b_q, mag_b_d;
    logic [NB_INST-1:0]    hi_w_q, hi_w_d;
    logic [NB_INST-1:0]    lo_w_q, lo_w_d;
    logic                  neg_q, neg_d;
    logic                  rem_neg_q, rem_neg_d;
    logic [NB_COUNT-1:0]   cnt_q, cnt_d;
    logic [NB_INST-1:0]    hi_q, hi_d;
    logic [NB_INST-1:0]    lo_q, lo_d;
    logic                  dbz_q, dbz_d;

    logic                  is_div;
    logic                  sign_a;
    logic                  sign_b;
    logic [NB_INST:0]      mul_sum;
    logic [NB_INST:0]      div_shift;
    logic [NB_INST:0]      div_diff;
    logic [2*NB_INST-1:0]  prod_fix;
    logic [NB_INST-1:0]    quo_fix;
    logic [NB_INST-1:0]    rem_fix;

    always_comb begin
        is_div  = op_q[1];
        sign_a  = ~op_q[0] & a_q[NB_INST-1];
        sign_b  = ~op_q[0] & b_q[NB_INST-1];
        // Multiply: HI accumulates the multiplicand when the current LO bit is set.
        mul_sum   = {1'b0, hi_w_q} + (lo_w_q[0] ? {1'b0, mag_b_q} : '0);
        // Divide: HI is the partial remainder, LO shifts dividend bits out and quotient bits in.
        div_shift = {hi_w_q, lo_w_q[NB_INST-1]};
        div_diff  = div_shift - {1'b0, mag_b_q};
        prod_fix  = neg_q ? neg_dw({hi_w_q, lo_w_q}) : {hi_w_q, lo_w_q};
        quo_fix   = neg_q ? neg_w(lo_w_q) : lo_w_q;
        rem_fix   = rem_neg_q ? neg_w(hi_w_q) : hi_w_q;
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        mag_b_d   = mag_b_q;
        hi_w_d    = hi_w_q;
        lo_w_d    = lo_w_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;
        o_stall   = (state_q != IDLE) || (i_start && !i_flush);
        o_done    = (state_q == DONE) && !i_flush;

        if (state_q != IDLE && i_flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_start && !i_flush) begin
                        op_d    = i_op;
                        a_d     = i_operand_a;
                        b_d     = i_operand_b;
                        state_d = PREP;
                    end
                end
                PREP: begin
                    neg_d     = sign_a ^ sign_b;
                    rem_neg_d = sign_a;
                    lo_w_d    = sign_a ? neg_w(a_q) : a_q;
                    mag_b_d   = sign_b ? neg_w(b_q) : b_q;
                    hi_w_d    = '0;
                    cnt_d     = '0;
                    if (is_div && b_q == '0) begin
                        hi_d    = a_q;
                        lo_d    = '1;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (!is_div) begin
                        {hi_w_d, lo_w_d} = {mul_sum, lo_w_q[NB_INST-1:1]};
                    end else if (!div_diff[NB_INST]) begin
                        hi_w_d = div_diff[NB_INST-1:0];
                        lo_w_d = {lo_w_q[NB_INST-2:0], 1'b1};
                    end else begin
                        hi_w_d = div_shift[NB_INST-1:0];
                        lo_w_d = {lo_w_q[NB_INST-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    if (!is_div) begin
                        {hi_d, lo_d} = prod_fix;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mag_b_q   <= '0;
            hi_w_q    <= '0;
            lo_w_q    <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            mag_b_q   <= mag_b_d;
            hi_w_q    <= hi_w_d;
            lo_w_q    <= lo_w_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dbz_q     <= dbz_d;
        end
    end

    assign o_hi          = hi_q;
    assign o_lo          = lo_q;
    assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Randomized self-checking bench for ex_muldiv_sequencer against a plain-arithmetic
// model of MIPS-style MULT/MULTU/DIV/DIVU, plus flush, busy-start and reset scenarios.
module tb_ex_muldiv_sequencer;

    logic        i_clk;
    logic        i_reset;
    logic        i_start;
    logic [1:0]  i_op;
    logic [31:0] i_operand_a;
    logic [31:0] i_operand_b;
    logic        i_flush;
    logic        o_stall;
    logic        o_done;
    logic [31:0] o_hi;
    logic [31:0] o_lo;
    logic        o_div_by_zero;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] exp_hi  = '0;
    logic [31:0] exp_lo  = '0;
    logic        exp_dbz = 1'b0;

    ex_muldiv_sequencer #(.NB_INST(32), .NB_COUNT(6)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_op         (i_op),
        .i_operand_a  (i_operand_a),
        .i_operand_b  (i_operand_b),
        .i_flush      (i_flush),
        .o_stall      (o_stall),
        .o_done       (o_done),
        .o_hi         (o_hi),
        .o_lo         (o_lo),
        .o_div_by_zero(o_div_by_zero)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: 64-bit host arithmetic, HI/LO split as the ISA defines them.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] r;
        logic [63:0]        p;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        dbz = 1'b0;
        hi  = '0;
        lo  = '0;
        case (op)
            2'b00: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
            default: begin
                if (b == 0) begin
                    hi = a; lo = 32'hFFFF_FFFF; dbz = 1'b1;
                end else if (op == 2'b10) begin
                    r = sa / sb; lo = r[31:0];
                    r = sa % sb; hi = r[31:0];
                end else begin
                    lo = a / b; hi = a % b;
                end
            end
        endcase
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        i_start = 1'b1; i_op = op; i_operand_a = a; i_operand_b = b;
        #1 chk("stall_accept", o_stall, 1);
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    // Called at the negedge of cycle t+1; waits for o_done and checks results and latency.
    task automatic finish_op(input int exp_lat, input bit poke);
        int  lat;
        bit  stall_ok;
        lat      = 0;
        stall_ok = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            if (k > 1) @(negedge i_clk);
            if (poke) begin
                if (k == 5) begin
                    i_start = 1'b1; i_op = 2'b01;
                    i_operand_a = $urandom; i_operand_b = $urandom;
                end else begin
                    i_start = 1'b0;
                end
                #1;
            end
            if (!o_stall) stall_ok = 1'b0;
            if (o_done) begin lat = k; break; end
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("stall_busy", {63'b0, stall_ok}, 1);
        chk("hi", {32'b0, o_hi}, {32'b0, exp_hi});
        chk("lo", {32'b0, o_lo}, {32'b0, exp_lo});
        chk("dbz", {63'b0, o_div_by_zero}, {63'b0, exp_dbz});
        @(negedge i_clk);
        chk("done_pulse", {63'b0, o_done}, 0);
        chk("stall_idle", {63'b0, o_stall}, 0);
        chk("hold_hi", {32'b0, o_hi}, {32'b0, exp_hi});
        chk("hold_lo", {32'b0, o_lo}, {32'b0, exp_lo});
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit poke);
        model(op, a, b, exp_hi, exp_lo, exp_dbz);
        issue(op, a, b);
        finish_op((op[1] && b == 0) ? 2 : 35, poke);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h0000_0000;
            3: return $urandom_range(0, 20);
            4: return -$urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit no_done;
        i_reset = 1'b0; i_start = 1'b0; i_op = '0;
        i_operand_a = '0; i_operand_b = '0; i_flush = 1'b0;
        repeat (2) @(negedge i_clk);
        chk("rst_hi", {32'b0, o_hi}, 0);
        chk("rst_lo", {32'b0, o_lo}, 0);
        chk("rst_dbz", {63'b0, o_div_by_zero}, 0);
        chk("rst_done", {63'b0, o_done}, 0);
        chk("rst_stall", {63'b0, o_stall}, 0);

        // Start on the very first edge after reset release.
        i_reset = 1'b1;
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("multu_max_hi", {32'b0, o_hi}, 64'hFFFF_FFFE);
        do_op(2'b00, 32'hFFFF_FFF9, 32'd3, 1'b0);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op(2'b11, 32'd7, 32'd0, 1'b0);
        chk("dbz_lo", {32'b0, o_lo}, 64'hFFFF_FFFF);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_ovf_lo", {32'b0, o_lo}, 64'h8000_0000);
        do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
        chk("mult_min_hi", {32'b0, o_hi}, 64'h4000_0000);
        do_op(2'b10, 32'd7, 32'd0, 1'b0);
        do_op(2'b00, 32'd5, 32'd6, 1'b0);

        for (int i = 0; i < 40; i++) begin
            do_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), 1'b0);
        end

        // Flush mid-RUN: no done, result registers keep the previous result.
        do_op(2'b00, 32'hFFFF_FFF9, 32'd3, 1'b0);
        issue(2'b01, 32'd5, 32'd5);
        no_done = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            if (k > 1) @(negedge i_clk);
            i_flush = (k == 10);
            #1;
            if (o_done) no_done = 1'b0;
        end
        chk("flush_no_done", {63'b0, no_done}, 1);
        chk("flush_idle", {63'b0, o_stall}, 0);
        chk("flush_hi", {32'b0, o_hi}, {32'b0, exp_hi});
        chk("flush_lo", {32'b0, o_lo}, {32'b0, exp_lo});
        do_op(2'b01, 32'd5, 32'd5, 1'b0);
        chk("after_flush_lo", {32'b0, o_lo}, 64'd25);

        // A start while busy must not disturb the running operation.
        do_op(2'b11, 32'd1000, 32'd7, 1'b1);
        do_op(2'b00, 32'hFFFF_FFF9, 32'd3, 1'b1);

        // Asynchronous reset mid-DIVU, observed before any clock edge.
        issue(2'b11, 32'd1000, 32'd7);
        repeat (19) @(negedge i_clk);
        #2 i_reset = 1'b0;
        #1;
        chk("arst_hi", {32'b0, o_hi}, 0);
        chk("arst_lo", {32'b0, o_lo}, 0);
        chk("arst_dbz", {63'b0, o_div_by_zero}, 0);
        chk("arst_stall", {63'b0, o_stall}, 0);
        chk("arst_done", {63'b0, o_done}, 0);
        repeat (2) @(negedge i_clk);
        i_reset = 1'b1;
        do_op(2'b10, 32'd100, 32'hFFFF_FFFD, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
